// File: rtl/key_schedule_ctrl.sv
// AES-128 key-expansion controller.
// Accepts one cipher key, generates round keys 0..NUM_ROUNDS one per clock
// into an internal bank, and serves them through a registered read port.
// g_function (RotWord, SubWord, Rcon) is kept as a separate module so the
// round pipeline can share the same transform.

module g_function (
  input  logic [31:0] word,
  input  logic [3:0]  round,
  output logic [31:0] result
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0] rot;
  logic [7:0]  rcon;

  // Round constant for rounds 1..10; other indices contribute nothing.
  always_comb begin
    rcon = '0;
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = '0;
    endcase
  end

  // RotWord, byte-wise SubWord, then Rcon into the most significant byte.
  always_comb begin
    rot    = {word[23:0], word[31:24]};
    result = {SBOX[rot[31:24]] ^ rcon, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  end

endmodule

module key_schedule_ctrl #(
  parameter int unsigned BLOCK_LENGTH = 128,
  parameter int unsigned NUM_ROUNDS   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic                    rd_en,
  input  logic [3:0]              rd_round,
  output logic [BLOCK_LENGTH-1:0] rd_key,
  output logic                    busy,
  output logic                    schedule_done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t                  state;
  logic [3:0]              counter;
  logic [BLOCK_LENGTH-1:0] work;
  logic [BLOCK_LENGTH-1:0] bank [NUM_ROUNDS+1];
  logic                    ready_q;
  logic [31:0]             g_out;
  logic [31:0]             w4, w5, w6, w7;
  logic [BLOCK_LENGTH-1:0] next_key;
  logic                    accept;

  g_function u_g (
    .word   (work[31:0]),
    .round  (counter),
    .result (g_out)
  );

  // Reset overrides the registered ready so no handshake can land on a reset edge.
  always_comb begin
    key_ready = ready_q & ~rst;
    accept    = key_valid & key_ready;
  end

  // One round of the key recurrence from the current working key.
  always_comb begin
    w4       = work[127:96] ^ g_out;
    w5       = work[95:64]  ^ w4;
    w6       = work[63:32]  ^ w5;
    w7       = work[31:0]   ^ w6;
    next_key = {w4, w5, w6, w7};
  end

  // Control FSM, working key and round-key bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      counter       <= '0;
      work          <= '0;
      ready_q       <= 1'b1;
      busy          <= 1'b0;
      schedule_done <= 1'b0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            bank[0]       <= key_in;
            work          <= key_in;
            counter       <= 4'd1;
            state         <= EXPAND;
            ready_q       <= 1'b0;
            busy          <= 1'b1;
            schedule_done <= 1'b0;
          end
        end
        EXPAND: begin
          bank[counter] <= next_key;
          work          <= next_key;
          // Counter parks on the last round instead of stepping past it.
          if (counter == LAST_ROUND) begin
            state         <= DONE;
            ready_q       <= 1'b1;
            busy          <= 1'b0;
            schedule_done <= 1'b1;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; sees bank contents from before any same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key <= '0;
    end else if (rd_en) begin
      if (rd_round <= LAST_ROUND) begin
        rd_key <= bank[rd_round];
      end else begin
        rd_key <= '0;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: scenario tasks compared against an AES-128
// key-expansion model built from GF(2^8) arithmetic.

module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst, key_valid, key_ready, rd_en, busy, schedule_done;
  logic [127:0] key_in, rd_key;
  logic [3:0]   rd_round;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb [256];
  logic [127:0] ref_rk [11];

  always #5 clk = ~clk;

  key_schedule_ctrl #(.BLOCK_LENGTH(128), .NUM_ROUNDS(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .rd_en         (rd_en),
    .rd_round      (rd_round),
    .rd_key        (rd_key),
    .busy          (busy),
    .schedule_done (schedule_done)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    d = d << n;
    return d[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = '0;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] idx, output logic [127:0] d);
    rd_en    = 1'b1;
    rd_round = idx;
    tick();
    d     = rd_key;
    rd_en = 1'b0;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents a key and returns right after the accepting edge (E0).
  task automatic handshake(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    for (int i = 0; i < 50 && key_ready !== 1'b1; i++) tick();
    n_checks++;
    if (key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_ready: key_ready=%b required 1", key_ready);
    end
    tick();
    key_valid = 1'b0;
  endtask

  // Counts edges after E0 until schedule_done, and cycles busy was seen high.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (schedule_done !== 1'b1 && edges < 30) begin
      tick();
      edges++;
      if (busy === 1'b1) busy_cyc++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; rd_en = 1'b0; rd_round = '0; key_in = '0;
    tick(); tick();
    n_checks++;
    if (key_ready !== 1'b0) begin n_fail++; $display("FAIL reset_key_ready: got %b required 0", key_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++;
    if (schedule_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", schedule_done); end
    n_checks++;
    if (rd_key !== '0) begin n_fail++; $display("FAIL reset_rd_key: got %h required 0", rd_key); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL idle_key_ready: got %b required 1", key_ready); end
  endtask

  task automatic test_fips_vector();
    int edges, bc;
    logic [127:0] d;
    handshake(128'h2b7e151628aed2a6abf7158809cf4f3c);
    n_checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      n_fail++; $display("FAIL e0_flags: busy=%b key_ready=%b required 1/0", busy, key_ready);
    end
    wait_done(edges, bc);
    n_checks++;
    if (edges != 10) begin n_fail++; $display("FAIL done_latency: got %0d edges required 10", edges); end
    n_checks++;
    if (busy !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL done_flags: busy=%b key_ready=%b required 0/1", busy, key_ready);
    end
    do_read(4'd0, d);
    n_checks++;
    if (d !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin n_fail++; $display("FAIL fips_r0: got %h required 2b7e151628aed2a6abf7158809cf4f3c", d); end
    do_read(4'd1, d);
    n_checks++;
    if (d !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL fips_r1: got %h required a0fafe1788542cb123a339392a6c7605", d); end
    do_read(4'd10, d);
    n_checks++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL fips_r10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
  endtask

  task automatic test_second_vector();
    int edges, bc;
    logic [127:0] d;
    handshake(128'h000102030405060708090a0b0c0d0e0f);
    wait_done(edges, bc);
    n_checks++;
    if (bc != 10) begin n_fail++; $display("FAIL busy_cycles: got %0d required 10", bc); end
    do_read(4'd10, d);
    n_checks++;
    if (d !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin n_fail++; $display("FAIL vec2_r10: got %h required 13111d7fe3944a17f307a78b4d2b30c5", d); end
  endtask

  task automatic test_ignore_during_expand();
    logic [127:0] ka, kb, d;
    ka = rand_key();
    kb = rand_key();
    compute_ref(ka);
    handshake(ka);
    for (int e = 1; e <= 10; e++) begin
      key_valid = (e <= 9) ? 1'(e % 2) : 1'b0;
      key_in    = kb;
      tick();
      if (e < 10) begin
        n_checks++;
        if (key_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_ready e%0d: got %b required 0", e, key_ready); end
      end else begin
        n_checks++;
        if (schedule_done !== 1'b1) begin n_fail++; $display("FAIL ignore_done: got %b required 1", schedule_done); end
      end
    end
    key_valid = 1'b0;
    for (int r = 0; r < 11; r++) begin
      do_read(4'(r), d);
      n_checks++;
      if (d !== ref_rk[r]) begin n_fail++; $display("FAIL ignore_r%0d: got %h required %h", r, d, ref_rk[r]); end
    end
  endtask

  task automatic test_reset_mid_expand();
    int edges, bc;
    logic [127:0] d;
    handshake(rand_key());
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (key_ready !== 1'b0) begin n_fail++; $display("FAIL rst_forces_ready: got %b required 0", key_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || schedule_done !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_flags: busy=%b done=%b ready=%b required 0/0/1", busy, schedule_done, key_ready);
    end
    for (int r = 0; r < 11; r++) begin
      do_read(4'(r), d);
      n_checks++;
      if (d !== '0) begin n_fail++; $display("FAIL cleared_r%0d: got %h required 0", r, d); end
    end
    d = rand_key();
    compute_ref(d);
    handshake(d);
    wait_done(edges, bc);
    n_checks++;
    if (edges != 10) begin n_fail++; $display("FAIL post_rst_latency: got %0d required 10", edges); end
    for (int r = 0; r < 11; r++) begin
      do_read(4'(r), d);
      n_checks++;
      if (d !== ref_rk[r]) begin n_fail++; $display("FAIL post_rst_r%0d: got %h required %h", r, d, ref_rk[r]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] old10, k2;
    old10 = ref_rk[10];
    k2 = rand_key();
    compute_ref(k2);
    handshake(k2);
    n_checks++;
    if (schedule_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b required 0", schedule_done); end
    tick(); tick();
    rd_en = 1'b1; rd_round = 4'd10;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_key !== old10) begin n_fail++; $display("FAIL b2b_stale_r10: got %h required %h", rd_key, old10); end
    for (int e = 4; e <= 10; e++) tick();
    n_checks++;
    if (schedule_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_e10: got %b required 1", schedule_done); end
    rd_en = 1'b1; rd_round = 4'd10;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_key !== ref_rk[10]) begin n_fail++; $display("FAIL b2b_new_r10: got %h required %h", rd_key, ref_rk[10]); end
  endtask

  task automatic test_read_port();
    logic [127:0] d, held;
    do_read(4'd5, d);
    n_checks++;
    if (d !== ref_rk[5]) begin n_fail++; $display("FAIL rd_r5: got %h required %h", d, ref_rk[5]); end
    held = ref_rk[5];
    for (int i = 0; i < 3; i++) begin
      rd_round = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (rd_key !== held) begin n_fail++; $display("FAIL rd_hold: got %h required %h", rd_key, held); end
    end
    do_read(4'd11, d);
    n_checks++;
    if (d !== '0) begin n_fail++; $display("FAIL rd_r11: got %h required 0", d); end
    do_read(4'd3, d);
    do_read(4'd15, d);
    n_checks++;
    if (d !== '0) begin n_fail++; $display("FAIL rd_r15: got %h required 0", d); end
  endtask

  task automatic test_random_keys();
    int edges, bc;
    logic [127:0] k, d;
    logic [3:0] idx;
    for (int n = 0; n < 4; n++) begin
      k = rand_key();
      compute_ref(k);
      handshake(k);
      wait_done(edges, bc);
      n_checks++;
      if (edges != 10 || bc != 10) begin
        n_fail++; $display("FAIL rand_timing: edges=%0d busy=%0d required 10/10", edges, bc);
      end
      for (int j = 0; j < 6; j++) begin
        idx = 4'($urandom_range(0, 15));
        do_read(idx, d);
        n_checks++;
        if (d !== ((idx <= 4'd10) ? ref_rk[idx] : 128'h0)) begin
          n_fail++; $display("FAIL rand_read r%0d: got %h required %h", idx, d, (idx <= 4'd10) ? ref_rk[idx] : 128'h0);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    init_sbox();
    test_reset();
    test_fips_vector();
    test_second_vector();
    test_ignore_during_expand();
    test_reset_mid_expand();
    test_back_to_back();
    test_read_port();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
